// File: rtl/chain0_master.sv
// chain0_master: byte-fed serial chain master driving scl/cs/din, with optional dout readback.
// Optional feature macro: CHAIN0_MASTER_READBACK_EN (dout capture into out_data/out_valid).
module chain0_master #(
   parameter int FRAME_BITS = 264,
   parameter int CLK_DIV    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       scl,
   output logic       cs,
   output logic       din,
   input  logic       dout,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       busy,
   output logic       done
);

   // state  | meaning
   // IDLE   | chain deselected, waiting for start
   // SETUP  | cs asserted, scl low for one half-period before the first byte
   // LOAD   | in_ready high, waiting for the next frame byte (no timeout)
   // SCL_LO | current bit on din, scl low for one half-period
   // SCL_HI | scl high for one half-period, then next bit / next byte / HOLD
   // HOLD   | scl low, cs still high for one half-period, then done
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETUP  = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] SCL_LO = 3'd3;
   localparam logic [2:0] SCL_HI = 3'd4;
   localparam logic [2:0] HOLD   = 3'd5;

   localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [7:0]       DIV_LOAD = 8'(CLK_DIV);

   logic [2:0]       state;
   logic [7:0]       divCnt;
   logic [CNT_W-1:0] bitCnt;
   logic [7:0]       shiftReg;
   logic             divTc;
   logic             sclRise;
   logic             lastBit;
   logic             byteEnd;

   assign divTc    = (divCnt == 8'd0);
   assign sclRise  = (state == SCL_LO) && divTc;
   assign lastBit  = (bitCnt == LAST_BIT);
   assign byteEnd  = (bitCnt[2:0] == 3'd7);
   assign in_ready = (state == LOAD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         divCnt   <= 8'd0;
         bitCnt   <= '0;
         shiftReg <= 8'd0;
         scl      <= 1'b0;
         cs       <= 1'b0;
         din      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!divTc) begin
            divCnt <= divCnt - 8'd1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= SETUP;
                  cs     <= 1'b1;
                  busy   <= 1'b1;
                  divCnt <= DIV_LOAD;
                  bitCnt <= '0;
               end
            end
            SETUP: begin
               if (divTc) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  shiftReg <= in_data;
                  din      <= in_data[7];
                  divCnt   <= DIV_LOAD;
                  state    <= SCL_LO;
               end
            end
            SCL_LO: begin
               if (divTc) begin
                  scl    <= 1'b1;
                  divCnt <= DIV_LOAD;
                  state  <= SCL_HI;
               end
            end
            SCL_HI: begin
               if (divTc) begin
                  scl    <= 1'b0;
                  divCnt <= DIV_LOAD;
                  if (lastBit) begin
                     state <= HOLD;
                  end else begin
                     bitCnt <= bitCnt + CNT_ONE;
                     if (byteEnd) begin
                        state <= LOAD;
                     end else begin
                        // din only changes here, after the full high phase of the previous bit
                        shiftReg <= {shiftReg[6:0], 1'b0};
                        din      <= shiftReg[6];
                        state    <= SCL_LO;
                     end
                  end
               end
            end
            HOLD: begin
               if (divTc) begin
                  cs    <= 1'b0;
                  din   <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CHAIN0_MASTER_READBACK_EN
   logic [6:0] capReg;
   logic [2:0] capCnt;

   // dout is taken on the edge that raises scl, i.e. before the chain shifts on that rise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         capReg    <= 7'd0;
         capCnt    <= 3'd0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (sclRise) begin
            capReg <= {capReg[5:0], dout};
            capCnt <= capCnt + 3'd1;
            if (capCnt == 3'd7) begin
               out_data  <= {capReg, dout};
               out_valid <= 1'b1;
            end
         end
      end
   end
`else
   logic unusedDout;
   logic unusedSclRise;
   assign unusedDout    = dout;
   assign unusedSclRise = sclRise;
   assign out_data      = 8'd0;
   assign out_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_chain0_master.sv
// Testbench for chain0_master: table of frame scenarios plus power-on and mid-frame reset sequences.
module tb_chain0_master;

   localparam int FB  = 264;
   localparam int NB  = FB / 8;
   localparam int DIV = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       scl;
   logic       cs;
   logic       din;
   logic       dout;
   logic [7:0] out_data;
   logic       out_valid;
   logic       busy;
   logic       done;

   int nCmp = 0;
   int nBad = 0;

   logic [7:0] frameBytes [NB];

   function automatic logic [FB-1:0] mkPreload();
      logic [FB-1:0] r;
      r = '0;
      for (int i = 0; i < NB; i++) r[FB-1-8*i -: 8] = 8'h3C + 8'(i);
      return r;
   endfunction

   // model of the external chain: shifts din in on scl rise, returns its MSB on dout
   logic [FB-1:0] chainSr = mkPreload();
   always @(posedge scl) chainSr <= {chainSr[FB-2:0], din};
   assign dout = chainSr[FB-1];

   always #5 clk = ~clk;

   chain0_master #(.FRAME_BITS(FB), .CLK_DIV(DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .scl       (scl),
      .cs        (cs),
      .din       (din),
      .dout      (dout),
      .out_data  (out_data),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string name, input logic [FB-1:0] got, input logic [FB-1:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic buildBytes(input logic [7:0] b0, input logic [7:0] fill, input logic [7:0] step);
      for (int i = 0; i < NB; i++)
         frameBytes[i] = (i == 0) ? b0 : 8'(int'(fill) + int'(step) * i);
   endtask

   // Runs one frame from the current time (just after a rising edge).
   task automatic runFrame(input string name, input int stallByte, input int stallLen,
                           input int restartAt, input int resetAt, input int expCs);
      int cyc, byteIdx, stallLeft, csCyc, doneCnt, busyBad, stallBad, dinBad;
      int nBits, rbCnt, rbBad, odBad, tail;
      logic [FB-1:0] gotBits, expBits, expRead;
      logic prevScl, hsPending, heldDin, timedOut;

      for (int i = 0; i < NB; i++) expBits[FB-1-8*i -: 8] = frameBytes[i];
      expRead = chainSr;
      gotBits = '0;
      cyc = 0; byteIdx = 0; stallLeft = stallLen; csCyc = 0; doneCnt = 0;
      busyBad = 0; stallBad = 0; dinBad = 0; nBits = 0; rbCnt = 0; rbBad = 0; odBad = 0;
      tail = 3; prevScl = 1'b0; hsPending = 1'b0; heldDin = 1'b0; timedOut = 1'b0;

      start = 1'b1; in_valid = 1'b1; in_data = frameBytes[0];
      @(posedge clk); #1;
      start = 1'b0;

      while (1) begin
         cyc++;
         if (hsPending) byteIdx++;
         if (cs) csCyc++;
         if (busy !== cs) busyBad++;
         if (scl && !prevScl) begin
            if (nBits < FB) gotBits[FB-1-nBits] = din;
            nBits++;
            heldDin = din;
         end else if (scl && din !== heldDin) begin
            dinBad++;
         end
         prevScl = scl;
`ifdef CHAIN0_MASTER_READBACK_EN
         if (out_valid) begin
            if (rbCnt < NB && out_data !== expRead[FB-1-8*rbCnt -: 8]) rbBad++;
            rbCnt++;
         end
`else
         if (out_valid !== 1'b0 || out_data !== 8'h00) odBad++;
`endif
         if (done) doneCnt++;
         if (doneCnt > 0) begin
            if (tail == 0) break;
            tail--;
         end

         if (cyc == resetAt) begin
            chk({name, "/active_before_reset"}, {cs, busy}, 2'b11);
            reset = 1'b1;
            #1;
            chk({name, "/reset_outputs"},
                {scl, cs, din, in_ready, busy, done, out_valid, out_data}, '0);
            in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk); #1;
               if (done) doneCnt++;
            end
            reset = 1'b0;
            @(posedge clk); #1;
            if (done) doneCnt++;
            chk({name, "/no_done_after_abort"}, doneCnt, 0);
            return;
         end

         start = (cyc == restartAt);
         if (byteIdx == stallByte && in_ready && stallLeft > 0) begin
            in_valid = 1'b0;
            stallLeft--;
            if (scl !== 1'b0 || cs !== 1'b1) stallBad++;
         end else begin
            in_valid = (byteIdx < NB);
            in_data  = frameBytes[(byteIdx < NB) ? byteIdx : 0];
         end
         hsPending = in_valid && in_ready;

         if (cyc > 5000) begin
            nCmp++; nBad++;
            $display("FAIL %s/timeout: no done after %0d cycles, required done", name, cyc);
            timedOut = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end

      start = 1'b0;
      in_valid = 1'b0;
      chk({name, "/cs_cycles"}, csCyc, expCs);
      chk({name, "/done_pulses"}, doneCnt, 1);
      chk({name, "/bit_count"}, nBits, FB);
      chk({name, "/first_byte_bits"}, gotBits[FB-1 -: 8], frameBytes[0]);
      chk({name, "/bit_sequence"}, gotBits, expBits);
      chk({name, "/busy_vs_cs"}, busyBad, 0);
      chk({name, "/din_stable"}, dinBad, 0);
      if (stallLen > 0) begin
         chk({name, "/stall_lines"}, stallBad, 0);
         chk({name, "/stall_applied"}, stallLeft, 0);
      end
`ifdef CHAIN0_MASTER_READBACK_EN
      chk({name, "/readback_strobes"}, rbCnt, NB);
      chk({name, "/readback_bytes"}, rbBad, 0);
`else
      chk({name, "/readback_off"}, odBad, 0);
`endif
      if (!timedOut) chk({name, "/idle_after"}, {busy, cs, in_ready, scl}, 4'b0000);
   endtask

   typedef struct {
      string      name;
      logic [7:0] b0;
      logic [7:0] fill;
      logic [7:0] step;
      int         stallByte;
      int         stallLen;
      int         restartAt;
      int         expCs;
   } vec_t;

   vec_t vecs [5];

   initial begin
      // H=2: 2*(2*264+2)=1060 cycles of phases, plus one LOAD cycle per byte and any stall
      vecs[0] = '{"a5_zero",    8'hA5, 8'h00, 8'h00, -1,  0,  -1, 1093};
      vecs[1] = '{"stall_b5",   8'h3C, 8'h11, 8'h25,  5, 20,  -1, 1113};
      vecs[2] = '{"restart",    8'hFF, 8'hF0, 8'h03, -1,  0, 100, 1093};
      vecs[3] = '{"stall_b0",   8'h81, 8'h7E, 8'h0D,  0,  3,  -1, 1096};
      vecs[4] = '{"stall_last", 8'h01, 8'h80, 8'h41, 32,  7,  -1, 1100};

      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("por/outputs", {scl, cs, din, in_ready, busy, done, out_valid, out_data}, '0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("por/idle", {scl, cs, busy, in_ready}, 4'b0000);

      for (int v = 0; v < 5; v++) begin
         buildBytes(vecs[v].b0, vecs[v].fill, vecs[v].step);
         runFrame(vecs[v].name, vecs[v].stallByte, vecs[v].stallLen,
                  vecs[v].restartAt, -1, vecs[v].expCs);
         repeat (2) @(posedge clk);
         #1;
      end

      buildBytes(8'hC7, 8'h29, 8'h13);
      runFrame("abort", -1, 0, -1, 300, 0);
      buildBytes(8'h5A, 8'hC3, 8'h07);
      runFrame("after_reset", -1, 0, -1, -1, 1093);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/chain0_master.md
CHAIN0_MASTER -- requirements
Module: chain0_master

Interface
REQ-001 Parameter FRAME_BITS, default 264, chain length in bits; SHALL be a multiple of 8 (264 = 33 bytes).
REQ-002 Parameter CLK_DIV, default 4, half-period of scl in clk cycles minus one; SHALL be 0..255.
REQ-003 Ports: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle frame request.
REQ-007 in_data  input  8  frame byte, byte 0 first, MSB-first on the chain.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  byte accepted when in_valid and in_ready are both high.
REQ-010 scl  output  1  serial clock to the chain, idle low.
REQ-011 cs  output  1  chain select, active-high for the whole frame.
REQ-012 din  output  1  serial data to the chain.
REQ-013 dout  input  1  serial data returned from the chain.
REQ-014 out_data  output  8  readback byte.
REQ-015 out_valid  output  1  one-cycle strobe qualifying out_data.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse at frame end.

Function
REQ-018 States: IDLE, SETUP, LOAD, SCL_LO, SCL_HI, HOLD; H = CLK_DIV+1 clk cycles.
REQ-019 IDLE: start=1 -> SETUP, busy=1, cs=1 on the next edge; start while busy SHALL be ignored.
REQ-020 SETUP: cs=1, scl=0 for H cycles -> LOAD.
REQ-021 LOAD: in_ready=1; on handshake, byte goes into the shift register -> SCL_LO; with no in_valid, stall in LOAD with scl=0 and cs=1, no timeout.
REQ-022 SCL_LO: din = current bit, scl=0 for H cycles -> SCL_HI.
REQ-023 SCL_HI: scl=1 for H cycles; din stable for the entire SCL_LO+SCL_HI span; after bit 7 of a byte -> LOAD, else -> SCL_LO with the next bit.
REQ-024 After bit FRAME_BITS-1 -> HOLD: scl=0, cs=1 for H cycles, then cs=0, busy=0, done=1 for one cycle -> IDLE.
REQ-025 Bit counter SHALL be wide enough for FRAME_BITS with no wrap inside a frame; byte count is FRAME_BITS/8 exactly.
REQ-026 scl, cs and din SHALL be driven directly from registers, glitch-free.
REQ-027 Uninterrupted frame: cs high for H*(2*FRAME_BITS+2) cycles, plus any LOAD cycles (at least one per byte).
REQ-028 in_ready SHALL be 0 outside LOAD; a start and a handshake in the same cycle cannot occur.

Reset
REQ-029 reset=1 SHALL immediately force scl=0, cs=0, din=0, in_ready=0, busy=0, done=0, out_valid=0, out_data=0, state=IDLE, and clear counters.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse; the next frame SHALL start from byte 0 after a new start.

Configuration
REQ-031 Macro CHAIN0_MASTER_READBACK_EN: when defined, dout SHALL be sampled in the clk cycle in which scl rises and shifted MSB-first into a capture register.
REQ-032 With the macro defined, out_valid SHALL pulse one cycle after every 8th sample, with out_data = the captured byte; FRAME_BITS/8 pulses per frame.
REQ-033 Without the macro, out_data=0 and out_valid=0 permanently, dout is ignored, and no capture logic is synthesised.

Verification
REQ-034 CLK_DIV=1, bytes 0xA5 then 0x00 x32 always valid, start -> first 8 din bits sampled on scl rising edges = 1,0,1,0,0,1,0,1; cs high 33*1+2*(2*264+2)=1093 cycles; one done pulse.
REQ-035 in_valid withheld for 20 cycles before byte 5 -> scl stays 0 and cs stays 1 through the stall; the bit sequence continues unchanged afterwards.
REQ-036 start pulsed again at cycle 100 of a frame -> ignored; exactly one done; busy drops only at frame end.
REQ-037 reset asserted at cycle 300 of a frame -> scl, cs and din are 0 in the same cycle with no done; a new start gives a correct full frame.
REQ-038 Readback enabled, dout looped to din through a model 264-bit shift register preloaded with 0x3C..., then a 2nd frame -> 1st frame out_data = preload bytes, 2nd frame out_data = 1st frame's bytes, 33 strobes each.
REQ-039 Macro undefined, dout toggling -> out_valid never asserts and out_data stays 0x00.
